spi_tx_feeder: RTL and testbench



---
 rtl/spi_tx_feeder.sv | 126 ++++++++++++
 tb/tb_spi_tx_feeder.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_feeder.sv
// Byte FIFO and pacing FSM in front of the single-byte SPI transmitter.
// Define SPI_TX_FEEDER_STATS_EN to add the byte_cnt output.
module spi_tx_feeder #(
  parameter int          DEPTH      = 16,
  parameter int          GAP_CYCLES = 4,
  parameter logic [7:0]  DIV_RESET  = 8'd4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic                     cfg_div_we,
  input  logic [7:0]               cfg_div,
  output logic                     tx_wr_en,
  output logic [7:0]               tx_wr_data,
  input  logic                     tx_wr_done,
  output logic [7:0]               tx_sclk_div,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
`ifdef SPI_TX_FEEDER_STATS_EN
  ,
  output logic [15:0]              byte_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push     = in_valid & ~full & ~flush;
  // head must exist before the edge, so a byte is never popped as it lands
  assign pop      = (state == IDLE) & ~empty & ~flush;

  assign in_ready   = ~full;
  assign tx_wr_en   = (state == SEND) & ~tx_wr_done;
  assign busy       = (state != IDLE) | ~empty;
  assign fifo_count = count;

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    unique case (state)
      IDLE: begin
        if (pop) state_nxt = SEND;
      end
      SEND: begin
        if (tx_wr_done) begin
          if (GAP_CYCLES == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = GAP;
            gap_nxt   = GW'(GAP_CYCLES);
          end
        end
      end
      GAP: begin
        if (gap_cnt <= GW'(1)) state_nxt = IDLE;
        else gap_nxt = gap_cnt - GW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_wr_data  <= 8'h00;
      tx_sclk_div <= DIV_RESET;
      overflow    <= 1'b0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (in_valid && full) overflow <= 1'b1;
      end
      if (pop) tx_wr_data <= mem[rd_ptr];
      if (cfg_div_we && state == IDLE && empty)
        tx_sclk_div <= cfg_div;
    end
  end

`ifdef SPI_TX_FEEDER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= 16'h0000;
    end else if (state == SEND && tx_wr_done) begin
      if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Self-checking bench for spi_tx_feeder: vector table, directed
// sequences and a randomized run against a queue-based model.
module tb_spi_tx_feeder;

  localparam int DEPTH = 16;
  localparam int G     = 4;
  localparam logic [7:0] DIVR = 8'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       flush;
  logic       cfg_div_we;
  logic [7:0] cfg_div;
  logic       tx_wr_en;
  logic [7:0] tx_wr_data;
  logic       tx_wr_done;
  logic [7:0] tx_sclk_div;
  logic       busy;
  logic [4:0] fifo_count;
  logic       overflow;
`ifdef SPI_TX_FEEDER_STATS_EN
  logic [15:0] byte_cnt;
`endif

  spi_tx_feeder #(
    .DEPTH(DEPTH),
    .GAP_CYCLES(G),
    .DIV_RESET(DIVR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .flush(flush),
    .cfg_div_we(cfg_div_we),
    .cfg_div(cfg_div),
    .tx_wr_en(tx_wr_en),
    .tx_wr_data(tx_wr_data),
    .tx_wr_done(tx_wr_done),
    .tx_sclk_div(tx_sclk_div),
    .busy(busy),
    .fifo_count(fifo_count),
    .overflow(overflow)
`ifdef SPI_TX_FEEDER_STATS_EN
    ,
    .byte_cnt(byte_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: queue of pending bytes plus transmit/gap status
  logic [7:0] mq[$];
  bit         m_send;
  int         m_gap;
  logic [7:0] m_cur;
  bit         m_ovf;
  logic [7:0] m_div;
  int         m_bc;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic void model_step();
    int sz   = mq.size();
    bit idle = !m_send && m_gap == 0;
    bit full = (sz == DEPTH);
    if (rst) begin
      mq.delete();
      m_send = 0;
      m_gap  = 0;
      m_cur  = 8'h00;
      m_ovf  = 0;
      m_div  = DIVR;
      m_bc   = 0;
      return;
    end
    if (cfg_div_we && idle && sz == 0) m_div = cfg_div;
    if (idle) begin
      if (sz > 0 && !flush) begin
        m_cur  = mq.pop_front();
        m_send = 1;
      end
    end else if (m_send) begin
      if (tx_wr_done) begin
        m_send = 0;
        m_gap  = G;
        if (m_bc < 65535) m_bc++;
      end
    end else begin
      m_gap--;
    end
    if (flush) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      if (in_valid && full) m_ovf = 1;
      if (in_valid && !full) mq.push_back(in_data);
    end
  endfunction

  task automatic check_all();
    bit idle = !m_send && m_gap == 0;
    chk("m_in_ready", in_ready, mq.size() < DEPTH);
    chk("m_wr_en", tx_wr_en, m_send && !tx_wr_done);
    chk("m_wr_data", tx_wr_data, m_cur);
    chk("m_sclk_div", tx_sclk_div, m_div);
    chk("m_busy", busy, !idle || mq.size() != 0);
    chk("m_count", fifo_count, mq.size());
    chk("m_overflow", overflow, m_ovf);
`ifdef SPI_TX_FEEDER_STATS_EN
    chk("m_byte_cnt", byte_cnt, m_bc);
`endif
  endtask

  task automatic cyc();
    #1;
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clr();
    in_valid   = 0;
    flush      = 0;
    cfg_div_we = 0;
    tx_wr_done = 0;
  endtask

  task automatic push1(input logic [7:0] d);
    in_valid = 1;
    in_data  = d;
    cyc();
    in_valid = 0;
  endtask

  task automatic wait_en(output int w);
    w = 0;
    while (!tx_wr_en && w < 200) begin
      cyc();
      w++;
    end
    chk("wait_en", tx_wr_en, 1);
  endtask

  // holds the byte for lat cycles, then pulses done
  task automatic xmit(input int lat);
    for (int i = 0; i < lat; i++) begin
      chk("en_hold", tx_wr_en, 1);
      cyc();
    end
    tx_wr_done = 1;
    #1;
    chk("en_low_done", tx_wr_en, 0);
    cyc();
    tx_wr_done = 0;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       we;
    logic [7:0] dv;
    logic       dn;
    logic       en;
    logic [7:0] dat;
    logic [4:0] cnt;
    logic       bsy;
    logic [7:0] div;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int w;
    int tmr;
    tbl[0] = '{1, 8'hA5, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h04};
    tbl[1] = '{0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 1, 8'h04};
    tbl[2] = '{0, 8'h00, 0, 8'h00, 0, 1, 8'hA5, 0, 1, 8'h04};
    tbl[3] = '{0, 8'h00, 0, 8'h00, 1, 0, 8'hA5, 0, 1, 8'h04};
    tbl[4] = '{0, 8'h00, 0, 8'h00, 0, 0, 8'hA5, 0, 1, 8'h04};
    tbl[5] = '{0, 8'h00, 0, 8'h00, 0, 0, 8'hA5, 0, 1, 8'h04};
    tbl[6] = '{0, 8'h00, 0, 8'h00, 0, 0, 8'hA5, 0, 1, 8'h04};
    tbl[7] = '{0, 8'h00, 0, 8'h00, 0, 0, 8'hA5, 0, 1, 8'h04};
    tbl[8] = '{0, 8'h00, 1, 8'h5A, 0, 0, 8'hA5, 0, 0, 8'h04};
    tbl[9] = '{0, 8'h00, 0, 8'h00, 0, 0, 8'hA5, 0, 0, 8'h5A};

    rst     = 1;
    in_data = 8'h00;
    cfg_div = 8'h00;
    clr();
    @(posedge clk);
    model_step();
    #1;
    rst = 0;

    chk("rst_in_ready", in_ready, 1);
    chk("rst_wr_en", tx_wr_en, 0);
    chk("rst_wr_data", tx_wr_data, 0);
    chk("rst_div", tx_sclk_div, 8'h04);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);

    for (int i = 0; i < 10; i++) begin
      in_valid   = tbl[i].v;
      in_data    = tbl[i].d;
      cfg_div_we = tbl[i].we;
      cfg_div    = tbl[i].dv;
      tx_wr_done = tbl[i].dn;
      #1;
      chk($sformatf("v%0d_en", i), tx_wr_en, tbl[i].en);
      chk($sformatf("v%0d_data", i), tx_wr_data, tbl[i].dat);
      chk($sformatf("v%0d_cnt", i), fifo_count, tbl[i].cnt);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("v%0d_div", i), tx_sclk_div, tbl[i].div);
      cyc();
    end
    clr();

    // single byte, 20-cycle transmitter
    push1(8'hA5);
    wait_en(w);
    chk("a5_latency", w, 1);
    chk("a5_data", tx_wr_data, 8'hA5);
    xmit(20);
    for (int i = 0; i < G; i++) begin
      chk("a5_gap_busy", busy, 1);
      chk("a5_gap_en", tx_wr_en, 0);
      cyc();
    end
    chk("a5_idle", busy, 0);

    // three bytes back to back
    in_valid = 1;
    in_data  = 8'h01;
    cyc();
    in_data = 8'h02;
    cyc();
    in_data = 8'h03;
    cyc();
    in_valid = 0;
    chk("b3_cnt0", fifo_count, 2);
    chk("b3_d1", tx_wr_data, 8'h01);
    xmit(3);
    wait_en(w);
    chk("b3_gap1", w, G + 1);
    chk("b3_d2", tx_wr_data, 8'h02);
    chk("b3_cnt1", fifo_count, 1);
    xmit(2);
    wait_en(w);
    chk("b3_gap2", w, G + 1);
    chk("b3_d3", tx_wr_data, 8'h03);
    chk("b3_cnt2", fifo_count, 0);
    xmit(1);
    repeat (G) cyc();
    chk("b3_idle", busy, 0);

    // overflow while transmitter stalls
    push1(8'hB0);
    wait_en(w);
    for (int i = 0; i < 17; i++) begin
      in_valid = 1;
      in_data  = 8'(8'h20 + i);
      if (i == 16) chk("of_ready", in_ready, 0);
      cyc();
    end
    in_valid = 0;
    chk("of_cnt", fifo_count, 16);
    chk("of_flag", overflow, 1);
    chk("of_ready2", in_ready, 0);
    flush = 1;
    cyc();
    flush = 0;
    chk("of_flush_cnt", fifo_count, 0);
    chk("of_flush_ovf", overflow, 0);
    xmit(2);
    repeat (G) cyc();
    chk("of_idle", busy, 0);

    // flush during SEND
    push1(8'h11);
    wait_en(w);
    for (int i = 0; i < 5; i++) push1(8'(8'h60 + i));
    chk("fl_cnt5", fifo_count, 5);
    flush = 1;
    cyc();
    flush = 0;
    chk("fl_cnt", fifo_count, 0);
    chk("fl_ovf", overflow, 0);
    chk("fl_en", tx_wr_en, 1);
    chk("fl_data", tx_wr_data, 8'h11);
    xmit(4);
    for (int i = 0; i < 12; i++) begin
      chk("fl_no_en", tx_wr_en, 0);
      cyc();
    end
    chk("fl_idle", busy, 0);

    // divider write while busy, then when idle
    push1(8'h77);
    wait_en(w);
    cfg_div_we = 1;
    cfg_div    = 8'h10;
    cyc();
    cfg_div_we = 0;
    chk("div_busy", tx_sclk_div, 8'h5A);
    xmit(2);
    repeat (G + 1) cyc();
    chk("div_idle0", busy, 0);
    cfg_div_we = 1;
    cyc();
    cfg_div_we = 0;
    chk("div_load", tx_sclk_div, 8'h10);

    // reset during SEND
    push1(8'h3C);
    wait_en(w);
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    chk("rs_en", tx_wr_en, 0);
    chk("rs_data", tx_wr_data, 0);
    chk("rs_div", tx_sclk_div, DIVR);
    chk("rs_busy", busy, 0);
    chk("rs_cnt", fifo_count, 0);
    chk("rs_ready", in_ready, 1);
    chk("rs_ovf", overflow, 0);
    tx_wr_done = 1;
    cyc();
    cyc();
    tx_wr_done = 0;
    chk("rs_late_en", tx_wr_en, 0);
    chk("rs_late_busy", busy, 0);

    // randomized traffic against the model
    tmr = 0;
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom % 2) == 0;
      in_data    = 8'($urandom);
      flush      = ($urandom % 40) == 0;
      cfg_div_we = ($urandom % 20) == 0;
      cfg_div    = 8'($urandom);
      rst        = ($urandom % 700) == 0;
      if (m_send) begin
        if (tmr == 0) begin
          tx_wr_done = 1;
          tmr = $urandom_range(0, 5);
        end else begin
          tx_wr_done = 0;
          tmr--;
        end
      end else begin
        tx_wr_done = ($urandom % 10) == 0;
      end
      cyc();
    end
    rst = 0;
    clr();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
